// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined memory slave with a 2-entry request buffer and a periodic refresh slot.
// Define WB_MEM_ERR_EN to return wb_err_o for word indices >= MEM_DEPTH instead of wrapping.
module wb_mem_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int READ_LAT       = 1,
    parameter int REFRESH_PERIOD = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic                    wb_stall_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef WB_MEM_ERR_EN
    localparam int IDX_W     = ADDR_WIDTH - 2;
`else
    localparam int IDX_W     = MEM_AW;
`endif

    typedef struct packed {
        logic                  we;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  sel;
    } req_t;

    req_t                  fifo_q [2];
    req_t                  head;
    req_t                  push_req;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_count;
    logic                  busy_slot;
    logic                  accept;
    logic                  issue;
    logic                  head_err;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  pipe_vld [READ_LAT];
    logic                  pipe_err [READ_LAT];
    logic [DATA_WIDTH-1:0] pipe_dat [READ_LAT];
    logic                  unused_adr;

    // Stall depends only on the registered occupancy, never on wb_stb_i.
    assign wb_stall_o = (fifo_count == 2'd2);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign issue      = wb_cyc_i & ~busy_slot & (fifo_count != 2'd0);
    assign head       = fifo_q[rd_ptr];
    assign push_req   = '{we: wb_we_i, idx: wb_adr_i[IDX_W+1:2], dat: wb_dat_i, sel: wb_sel_i};
    assign unused_adr = &{1'b0, wb_adr_i};

`ifdef WB_MEM_ERR_EN
    localparam logic [IDX_W-1:0] DEPTH_LIM = IDX_W'(MEM_DEPTH);
    assign head_err = (head.idx >= DEPTH_LIM);
    assign mem_idx  = head.idx[MEM_AW-1:0];
`else
    assign head_err = 1'b0;
    assign mem_idx  = head.idx;
`endif

    generate
        if (REFRESH_PERIOD == 0) begin : g_no_refresh
            assign busy_slot = 1'b0;
        end else begin : g_refresh
            localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [RW-1:0] refresh_cnt;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    refresh_cnt <= RW'(REFRESH_PERIOD - 1);
                    busy_slot   <= 1'b0;
                end else if (refresh_cnt == '0) begin
                    refresh_cnt <= RW'(REFRESH_PERIOD - 1);
                    busy_slot   <= 1'b1;
                end else begin
                    refresh_cnt <= refresh_cnt - RW'(1);
                    busy_slot   <= 1'b0;
                end
            end
        end
    endgenerate

    // A dropped wb_cyc_i empties the buffer; queued writes are lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !wb_cyc_i) begin
            fifo_count <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (issue)  rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, accept} - {1'b0, issue};
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by fifo_count and pipe_vld alone.
    always_ff @(posedge wb_clk_i) begin
        if (accept) fifo_q[wr_ptr] <= push_req;
    end

    always_ff @(posedge wb_clk_i) begin
        if (issue && head.we && !head_err) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (head.sel[b]) mem[mem_idx][b*8 +: 8] <= head.dat[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_err[i] <= 1'b0;
                pipe_dat[i] <= '0;
            end
        end else if (!wb_cyc_i) begin
            for (int i = 0; i < READ_LAT; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_err[0] <= issue & head_err;
            pipe_dat[0] <= (issue && !head.we && !head_err) ? mem[mem_idx] : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign wb_ack_o = wb_cyc_i & pipe_vld[READ_LAT-1] & ~pipe_err[READ_LAT-1];
    assign wb_err_o = wb_cyc_i & pipe_vld[READ_LAT-1] &  pipe_err[READ_LAT-1];
    assign wb_dat_o = pipe_dat[READ_LAT-1];

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Wishbone B4 pipelined slave with on-chip single-port memory.
- Responder end of the L1 miss/refill bus: it accepts pipelined single-beat reads and writes, such as 4-beat line refills issued back-to-back, and returns in-order acks.
- A periodic one-cycle memory-busy slot ("refresh") and a 2-entry request buffer produce real wb_stall_o back-pressure, so initiator stall handling gets exercised.

Parameters:
- ADDR_WIDTH, 32: wb_adr_i width; byte address, word index = adr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32: data width; sel width = DATA_WIDTH/8.
- MEM_DEPTH, 1024: words of storage; must be a power of two when WB_MEM_ERR_EN is off.
- READ_LAT, 1: response pipeline stages after memory issue; legal range 1..4.
- REFRESH_PERIOD, 16: cycles between busy slots; 0 disables refresh.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables for writes.
- wb_stall_o  out  1  request not accepted this cycle.
- wb_ack_o  out  1  one-cycle response per accepted request.
- wb_err_o  out  1  error response, used only with WB_MEM_ERR_EN.
- wb_dat_o  out  DATA_WIDTH  read data, valid while wb_ack_o is high.

Behaviour:
- Reset (synchronous, active-high):
  - Clears request FIFO, issue stage, response pipeline valids and wb_dat_o.
  - Loads refresh counter with REFRESH_PERIOD-1.
  - Outputs after reset: wb_ack_o=0, wb_err_o=0, wb_stall_o=0, wb_dat_o=0.
  - Memory contents are not reset.
  - Reset mid-burst discards all pending requests; no ack follows.
- Accept: a request is accepted on an edge where wb_cyc_i & wb_stb_i & ~wb_stall_o. It is pushed into the FIFO with {we, word index, dat, sel}.
- Stall: wb_stall_o = (fifo_count == 2). It is decoded from a register, with no combinational path from wb_stb_i.
- Issue:
  - Each cycle that is not a refresh slot and has a non-empty FIFO, the head pops and accesses memory.
  - Write: bytes where sel=1 are updated.
  - Read: the word is registered.
  - No FIFO bypass.
- Latency:
  - Request accepted at the end of cycle c, with an empty FIFO and no refresh slot, gives wb_ack_o high in cycle c+1+READ_LAT. Default READ_LAT=1 gives a 2-cycle latency.
  - Throughput is one request per cycle.
- Writes are acked with the same latency, and wb_dat_o=0 on a write ack.
- Ordering: strictly in order. A read after a write to the same word returns the new data.
- Simultaneous push and pop: fifo_count is unchanged. Push is never attempted while full, because stall is high.
- Refresh:
  - The counter decrements every cycle, independent of wb_cyc_i.
  - At 0, the next cycle is a busy slot (no issue) and the counter reloads REFRESH_PERIOD-1.
  - In a continuous burst, a busy slot raises fifo_count to 2. Stall is then high for one cycle and clears as the FIFO drains.
- Bus-cycle abort: on an edge where wb_cyc_i=0:
  - FIFO and response-pipeline valids are cleared.
  - Writes already issued to memory stay committed; writes still in the FIFO are dropped.
  - wb_ack_o and wb_err_o are forced 0 while wb_cyc_i=0.
- Responses per request: exactly one of ack/err, never both.

Optional Feature:
- Macro: WB_MEM_ERR_EN.
- Defined:
  - A word index >= MEM_DEPTH performs no memory access and suppresses any write.
  - It gets wb_err_o=1 (wb_ack_o=0, wb_dat_o=0) in the slot where its ack would occur.
  - Ordering and latency are unchanged.
- Undefined:
  - The index is truncated to clog2(MEM_DEPTH) bits, so the address wraps.
  - wb_err_o is tied to 0.

Test Plan:
- Reset, then one read of adr 0x10 with preloaded word 0xDEADBEEF -> stall low throughout; ack exactly 2 cycles after the stb cycle with dat_o=0xDEADBEEF.
- 4-beat burst, write adr 0x20..0x2C with data 1..4 and sel=4'hF, then 4 back-to-back reads -> 8 acks in order; reads return 1,2,3,4.
- Partial write sel=4'b0010 with data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- REFRESH_PERIOD=4 with a 12-beat continuous read burst -> stall high one cycle after each busy slot; 12 acks, no loss or duplication, data in address order.
- wb_cyc_i dropped after 2 of 4 accepted reads -> at most acks already due before the drop; none after; the next cycle's single read acks normally.
- WB_MEM_ERR_EN, MEM_DEPTH=1024, read adr 0x1000 then read 0x0 -> err then ack, in order; write to 0x1000 leaves memory unchanged. Without the macro, 0x1000 aliases 0x0.
